// File: rtl/sc_local_velocity_pkg.sv
// sc_local_velocity_pkg: fixed-point formats, CORDIC constants, FSM states and sign-magnitude helpers
package sc_local_velocity_pkg;
    localparam int N_WIDTH = 32;
    localparam int Q_WIDTH = 15;
    localparam int ITER = 16;
    localparam int IW = $clog2(ITER);
    localparam int C_WIDTH = 17;
    typedef logic signed [N_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, ROT, MUL, SUM} state_t;
    localparam logic signed [C_WIDTH-1:0] CORDIC_K = 17'sd19899;
    localparam word_t THETA_MAX = 32'sd2949120;
    localparam word_t SAT_MAX = 32'sh7fff_ffff;
    // atan(2^-i) in degrees, Q15
    localparam word_t ATAN [ITER] = '{
        32'sd1474560, 32'sd870484, 32'sd459940, 32'sd233473,
        32'sd117189, 32'sd58652, 32'sd29333, 32'sd14667,
        32'sd7334, 32'sd3667, 32'sd1833, 32'sd917,
        32'sd458, 32'sd229, 32'sd115, 32'sd57
    };
    function automatic word_t sm_to_tc(input logic [N_WIDTH-1:0] v);
        word_t m;
        m = word_t'({1'b0, v[N_WIDTH-2:0]});
        return v[N_WIDTH-1] ? -m : m;
    endfunction
    // zero always maps to +0, so negative zero never leaves the block
    function automatic logic [N_WIDTH-1:0] tc_to_sm(input word_t v);
        word_t m;
        m = v[N_WIDTH-1] ? -v : v;
        return {v[N_WIDTH-1], m[N_WIDTH-2:0]};
    endfunction
endpackage

// File: rtl/sc_local_velocity_if.sv
// sc_local_velocity_if: request/result bundle between the trajectory planner and the local transform
interface sc_local_velocity_if;
    import sc_local_velocity_pkg::N_WIDTH;
    logic start;
    logic ready;
    logic done;
    logic ovf;
    logic [N_WIDTH-1:0] vx_global;
    logic [N_WIDTH-1:0] vy_global;
    logic [N_WIDTH-1:0] wz_global;
    logic [N_WIDTH-1:0] theta;
    logic [N_WIDTH-1:0] vx_local;
    logic [N_WIDTH-1:0] vy_local;
    logic [N_WIDTH-1:0] wz_local;
    modport master (
        output start, vx_global, vy_global, wz_global, theta,
        input ready, done, ovf, vx_local, vy_local, wz_local
    );
    modport slave (
        input start, vx_global, vy_global, wz_global, theta,
        output ready, done, ovf, vx_local, vy_local, wz_local
    );
endinterface

// File: rtl/sc_cordic_iter.sv
// sc_cordic_iter: rotation-mode CORDIC in degrees, one iteration per clock, yields cos/sin in Q15
module sc_cordic_iter
    import sc_local_velocity_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  word_t theta,
    output logic signed [C_WIDTH-1:0] cos_th,
    output logic signed [C_WIDTH-1:0] sin_th,
    output logic done
);
    logic signed [C_WIDTH-1:0] x, y;
    word_t z;
    logic [IW-1:0] cnt;
    logic busy;
    logic neg;
    assign neg = z[N_WIDTH-1];
    assign done = busy && cnt == IW'(ITER - 1);
    assign cos_th = x;
    assign sin_th = y;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x <= '0;
            y <= '0;
            z <= '0;
            cnt <= '0;
            busy <= 1'b0;
        end else if (load) begin
            x <= CORDIC_K;
            y <= '0;
            z <= theta;
            cnt <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            x <= neg ? x + (y >>> cnt) : x - (y >>> cnt);
            y <= neg ? y - (x >>> cnt) : y + (x >>> cnt);
            z <= neg ? z + ATAN[cnt] : z - ATAN[cnt];
            cnt <= cnt + 1'b1;
            busy <= !done;
        end
endmodule

// File: rtl/sc_local_velocity.sv
// sc_local_velocity: global->local velocity rotation with CORDIC sin/cos and one shared multiplier.
// SC_LOCAL_VELOCITY_ROUND_EN selects round-half-up on the product shift instead of truncation.
module sc_local_velocity
    import sc_local_velocity_pkg::*;
(
    input logic clk,
    input logic rst_n,
    sc_local_velocity_if.slave bus
);
    localparam int PW = N_WIDTH + C_WIDTH;
    localparam int SW = PW - Q_WIDTH;
    localparam logic signed [SW:0] SAT_HI = (SW+1)'(SAT_MAX);
`ifdef SC_LOCAL_VELOCITY_ROUND_EN
    localparam int RND = 1 << (Q_WIDTH - 1);
`else
    localparam int RND = 0;
`endif
    state_t state, state_nx;
    logic [1:0] mul_cnt;
    word_t vx, vy, wz;
    word_t theta_in, theta_c;
    logic theta_ovf;
    logic accept;
    logic cordic_done;
    logic signed [C_WIDTH-1:0] c, s;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] p [4];
    logic signed [SW:0] sum_x, sum_y;
    logic sat_x, sat_y;
    word_t sx, sy;
    assign bus.ready = state == IDLE;
    assign accept = state == IDLE && bus.start;
    assign theta_in = sm_to_tc(bus.theta);
    assign theta_ovf = theta_in > THETA_MAX || theta_in < -THETA_MAX;
    assign theta_c = theta_ovf ? (theta_in[N_WIDTH-1] ? -THETA_MAX : THETA_MAX) : theta_in;
    sc_cordic_iter u_cordic (
        .clk(clk),
        .rst_n(rst_n),
        .load(accept),
        .theta(theta_c),
        .cos_th(c),
        .sin_th(s),
        .done(cordic_done)
    );
    // product order: vx*c, vy*s, vx*s, vy*c
    assign prod = PW'(mul_cnt[0] ? vy : vx) * PW'(^mul_cnt ? s : c);
    assign sum_x = (SW+1)'(p[0]) + (SW+1)'(p[1]);
    assign sum_y = (SW+1)'(p[3]) - (SW+1)'(p[2]);
    assign sat_x = sum_x > SAT_HI || sum_x < -SAT_HI;
    assign sat_y = sum_y > SAT_HI || sum_y < -SAT_HI;
    assign sx = sat_x ? (sum_x[SW] ? -SAT_MAX : SAT_MAX) : N_WIDTH'(sum_x);
    assign sy = sat_y ? (sum_y[SW] ? -SAT_MAX : SAT_MAX) : N_WIDTH'(sum_y);
    always_comb
        state_nx = state == IDLE ? (bus.start ? ROT : IDLE)
                 : state == ROT  ? (cordic_done ? MUL : ROT)
                 : state == MUL  ? (mul_cnt == 2'd3 ? SUM : MUL)
                 : IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            mul_cnt <= '0;
            vx <= '0;
            vy <= '0;
            wz <= '0;
            p <= '{default: '0};
            bus.done <= 1'b0;
            bus.ovf <= 1'b0;
            bus.vx_local <= '0;
            bus.vy_local <= '0;
            bus.wz_local <= '0;
        end else begin
            state <= state_nx;
            bus.done <= state == SUM;
            mul_cnt <= state == MUL ? mul_cnt + 2'd1 : 2'd0;
            if (state == MUL)
                p[mul_cnt] <= SW'((prod + PW'(RND)) >>> Q_WIDTH);
            if (accept) begin
                vx <= sm_to_tc(bus.vx_global);
                vy <= sm_to_tc(bus.vy_global);
                wz <= sm_to_tc(bus.wz_global);
                bus.ovf <= theta_ovf;
            end else if (state == SUM) begin
                bus.vx_local <= tc_to_sm(sx);
                bus.vy_local <= tc_to_sm(sy);
                bus.wz_local <= tc_to_sm(wz);
                bus.ovf <= bus.ovf | sat_x | sat_y;
            end
        end
endmodule

// File: tb/tb_sc_local_velocity.sv
// tb_sc_local_velocity: scoreboard bench with a real-valued rotation model and randomized requests
module tb_sc_local_velocity;
    localparam real PI = 3.14159265358979;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint TH_LIM = 64'sd2949120;
    typedef struct {
        longint vx;
        longint vy;
        longint tol;
        logic [31:0] wz;
        bit ovf;
        bit ovf_th;
        longint acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    longint cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb [$];
    exp_t m;
    sc_local_velocity_if bus ();
    sc_local_velocity dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic longint sm2int(input logic [31:0] v);
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction
    function automatic logic [31:0] int2sm(input longint v);
        return v < 0 ? {1'b1, 31'(-v)} : {1'b0, 31'(v)};
    endfunction
    function automatic longint labs(input longint v);
        return v < 0 ? -v : v;
    endfunction
    function automatic real rabs(input real v);
        return v < 0.0 ? -v : v;
    endfunction
    function automatic longint sat(input real f);
        return f > real'(MAXV) ? MAXV : f < -real'(MAXV) ? -MAXV : longint'(f);
    endfunction
    task automatic chk(input string name, input bit ok, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, expv, $time);
        end
    endtask
    task automatic issue(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] wz, input logic [31:0] th);
        exp_t e;
        real r, fvx, fvy, fx, fy;
        longint thi;
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", bus.ready == 1'b1, longint'(bus.ready), 1);
        bus.vx_global = vx;
        bus.vy_global = vy;
        bus.wz_global = wz;
        bus.theta = th;
        bus.start = 1'b1;
        thi = sm2int(th);
        e.ovf_th = thi > TH_LIM || thi < -TH_LIM;
        thi = thi > TH_LIM ? TH_LIM : thi < -TH_LIM ? -TH_LIM : thi;
        r = real'(thi) / 32768.0 * PI / 180.0;
        fvx = real'(sm2int(vx));
        fvy = real'(sm2int(vy));
        fx = fvx * $cos(r) + fvy * $sin(r);
        fy = -fvx * $sin(r) + fvy * $cos(r);
        e.vx = sat(fx);
        e.vy = sat(fy);
        e.ovf = e.ovf_th || labs(sat(fx)) == MAXV && rabs(fx) > real'(MAXV)
                         || labs(sat(fy)) == MAXV && rabs(fy) > real'(MAXV);
        e.tol = 4 + (labs(sm2int(vx)) + labs(sm2int(vy))) / 8192;
        e.wz = wz == 32'h8000_0000 ? 32'd0 : wz;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.vx_global = $urandom;
        bus.vy_global = $urandom;
        bus.wz_global = $urandom;
        bus.theta = $urandom;
        chk("ovf_on_accept", bus.ovf == e.ovf_th, longint'(bus.ovf), longint'(e.ovf_th));
    endtask
    task automatic drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size() == 0, longint'(sb.size()), 0);
    endtask
    always @(negedge clk)
        if (rst_n && bus.done) begin
            if (sb.size() == 0)
                chk("unexpected_done", 1'b0, 1, 0);
            else begin
                m = sb.pop_front();
                chk("latency", cyc - m.acc == 21, cyc - m.acc, 21);
                chk("vx_local", labs(sm2int(bus.vx_local) - m.vx) <= m.tol && bus.vx_local != 32'h8000_0000,
                    sm2int(bus.vx_local), m.vx);
                chk("vy_local", labs(sm2int(bus.vy_local) - m.vy) <= m.tol && bus.vy_local != 32'h8000_0000,
                    sm2int(bus.vy_local), m.vy);
                chk("wz_local", bus.wz_local == m.wz, longint'(bus.wz_local), longint'(m.wz));
                chk("ovf_done", bus.ovf == m.ovf, longint'(bus.ovf), longint'(m.ovf));
                chk("ready_at_done", bus.ready == 1'b1, longint'(bus.ready), 1);
            end
        end
    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.vx_global = '0;
        bus.vy_global = '0;
        bus.wz_global = '0;
        bus.theta = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.ready == 1'b1, longint'(bus.ready), 1);
        chk("rst_done", bus.done == 1'b0, longint'(bus.done), 0);
        chk("rst_ovf", bus.ovf == 1'b0, longint'(bus.ovf), 0);
        chk("rst_outs", (bus.vx_local | bus.vy_local | bus.wz_local) == 32'd0,
            longint'(bus.vx_local | bus.vy_local | bus.wz_local), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd32768, 32'd16384, 32'h0001_2345, 32'd0);
        issue(32'd32768, 32'd65536, 32'h8000_4000, 32'd2949120);
        issue(32'd65536, 32'd0, 32'h0000_3000, 32'd983040);
        issue(32'h7fff_ffff, 32'h7fff_ffff, 32'd1, 32'd1474560);
        issue(32'd32768, 32'd0, 32'd2, 32'd0);
        issue(32'd32768, 32'd16384, 32'd3, 32'h802f_8000);
        issue(32'h8000_0000, 32'd16384, 32'h8000_0000, 32'h8000_0000);
        issue(32'd16384, 32'd16384, 32'd5, 32'd491520);
        repeat (4) @(negedge clk);
        chk("busy_ready", bus.ready == 1'b0, longint'(bus.ready), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain(100);
        issue(32'd65536, 32'd32768, 32'd7, 32'd983040);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", bus.ready == 1'b1, longint'(bus.ready), 1);
        chk("abort_done", bus.done == 1'b0, longint'(bus.done), 0);
        chk("abort_outs", (bus.vx_local | bus.vy_local | bus.wz_local) == 32'd0,
            longint'(bus.vx_local | bus.vy_local | bus.wz_local), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        issue(32'd32768, 32'd16384, 32'd9, 32'd0);
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4)) @(negedge clk);
            issue(int2sm(longint'($urandom_range(0, 131072)) - 65536),
                  int2sm(longint'($urandom_range(0, 131072)) - 65536),
                  $urandom,
                  int2sm(longint'($urandom_range(0, 6553600)) - 3276800));
        end
        drain(100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
